// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-word holding buffer for gapless back-to-back frames.
// rst_n is an asynchronous, active-high reset despite its name; tx_out is driven straight from a flop.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;

    logic                 accept;
    logic                 bit_end;
    logic                 frame_end;
    logic                 load_word;
    logic [DATA_BITS-1:0] load_val;

    always_comb begin
        accept      = tx_valid && !hold_full_q;
        bit_end     = (baud_cnt_q == LAST_CNT);
        frame_end   = (state_q == STOP) && bit_end && (bit_idx_q == LAST_STOP);

        state_d     = state_q;
        baud_cnt_d  = '0;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        parity_d    = parity_q;
        load_word   = 1'b0;
        load_val    = tx_data;

        // The baud counter only runs while a frame is on the line.
        if (state_q != IDLE && !bit_end) begin
            baud_cnt_d = baud_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_word = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        if (PARITY_EN) begin
                            state_d = PARITY;
                        end else begin
                            state_d = STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                end
            end
            STOP: begin
                if (frame_end) begin
                    state_d   = IDLE;
                    bit_idx_d = '0;
                    // A buffered word wins; otherwise a word offered right now starts immediately.
                    if (hold_full_q) begin
                        load_word   = 1'b1;
                        load_val    = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        load_word = 1'b1;
                    end
                end else if (bit_end) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept && !load_word) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (load_word) begin
            state_d   = START;
            shift_d   = load_val;
            parity_d  = (^load_val) ^ PARITY_ODD;
            bit_idx_d = '0;
        end

        // Line level is computed from the next state so the registered pin lines up with the state.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            parity_q    <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            parity_q    <= parity_d;
            tx_q        <= tx_d;
        end
    end

    assign tx_out     = tx_q;
    assign tx_ready   = !hold_full_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_end;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations checked each cycle against a sample-stream model,
// plus literal expectations for the directed frames.
`timescale 1ns/1ps
module tb_uart_tx_param;
    localparam int ND  = 4;
    localparam int CPB = 4;
    localparam int DB [ND] = '{8, 8, 8, 7};
    localparam int PE [ND] = '{0, 1, 1, 0};
    localparam int PO [ND] = '{0, 0, 1, 0};
    localparam int SB [ND] = '{1, 1, 1, 2};

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [ND-1:0] valid = '0;
    logic [8:0]    data [ND];
    logic [ND-1:0] ready, txo, busy, fdone;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[0][7:0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx_out(txo[0]), .busy(busy[0]), .frame_done(fdone[0]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[1][7:0]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx_out(txo[1]), .busy(busy[1]), .frame_done(fdone[1]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[2][7:0]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx_out(txo[2]), .busy(busy[2]), .frame_done(fdone[2]));
    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .tx_data(data[3][6:0]), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx_out(txo[3]), .busy(busy[3]), .frame_done(fdone[3]));

    // Model: the expected line, one entry per clk cycle, for the frame in flight.
    bit        samp [ND][256];
    int        len [ND];
    int        pos [ND];
    bit        mbuf_v [ND];
    bit [8:0]  mbuf_w [ND];
    bit        acc [ND];

    int n_checks = 0;
    int n_fail   = 0;

    logic cap_tx [0:127];
    logic cap_fd [0:127];
    logic cap_rdy [0:127];
    logic cap_busy [0:127];

    task automatic check(input string name, input int d, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %b, expected %b at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input bit b);
        for (int c = 0; c < CPB; c++) begin
            samp[d][len[d]] = b;
            len[d]++;
        end
    endtask

    task automatic load_frame(input int d, input bit [8:0] w);
        bit p;
        p = (PO[d] != 0);
        len[d] = 0;
        pos[d] = 0;
        push(d, 1'b0);
        for (int i = 0; i < DB[d]; i++) begin
            push(d, w[i]);
            p = p ^ w[i];
        end
        if (PE[d] != 0) push(d, p);
        for (int s = 0; s < SB[d]; s++) push(d, 1'b1);
    endtask

    task automatic model_step();
        bit a;
        if (rst_n) begin
            for (int d = 0; d < ND; d++) begin
                len[d] = 0; pos[d] = 0; mbuf_v[d] = 1'b0; acc[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                a = valid[d] && !mbuf_v[d];
                acc[d] = a;
                if (a) $display("dut%0d accepted word %h at %0t", d, data[d], $time);
                if (pos[d] < len[d]) begin
                    pos[d]++;
                    if (pos[d] == len[d]) begin
                        if (mbuf_v[d]) begin
                            load_frame(d, mbuf_w[d]);
                            mbuf_v[d] = 1'b0;
                        end else if (a) begin
                            load_frame(d, data[d]);
                            a = 1'b0;
                        end
                    end
                    if (a) begin
                        mbuf_v[d] = 1'b1;
                        mbuf_w[d] = data[d];
                    end
                end else if (a) begin
                    load_frame(d, data[d]);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst_n);
        model_step();
    end

    initial begin : compare_proc
        bit mt, mb, mf, mr;
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                mb = (pos[d] < len[d]);
                mt = mb ? samp[d][pos[d]] : 1'b1;
                mf = ((len[d] - pos[d]) == 1);
                mr = !mbuf_v[d];
                check("tx_out", d, txo[d], mt);
                check("tx_ready", d, ready[d], mr);
                check("busy", d, busy[d], mb);
                check("frame_done", d, fdone[d], mf);
            end
        end
    end

    task automatic send(input int d, input logic [8:0] w);
        bit done;
        done = 1'b0;
        data[d]  = w;
        valid[d] = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk);
            #1;
            if (acc[d]) done = 1'b1;
        end
        valid[d] = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL send_timeout dut%0d: word %h not accepted, required acceptance within 200 cycles", d, w);
        end
    endtask

    task automatic wait_idle(input int d);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (pos[d] >= len[d] && !mbuf_v[d]) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL idle_timeout dut%0d: still busy, required idle within 400 cycles", d);
        end
    endtask

    task automatic capture(input int d, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_tx[k]   = txo[d];
            cap_fd[k]   = fdone[d];
            cap_rdy[k]  = ready[d];
            cap_busy[k] = busy[d];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [9:0]  exp_a5;
    logic [10:0] exp_par_e, exp_par_o;
    logic [9:0]  exp_55;

    initial begin
        for (int d = 0; d < ND; d++) data[d] = '0;
        exp_a5    = {1'b1, 8'hA5, 1'b0};
        exp_par_e = {1'b1, 1'b0, 8'hA5, 1'b0};
        exp_par_o = {1'b1, 1'b1, 8'hA5, 1'b0};
        exp_55    = {2'b11, 7'h55, 1'b0};

        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("rst_tx_out", d, txo[d], 1'b1);
            check("rst_tx_ready", d, ready[d], 1'b1);
            check("rst_busy", d, busy[d], 1'b0);
            check("rst_frame_done", d, fdone[d], 1'b0);
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 8N1, 0xA5 from idle
        send(0, 9'h0A5);
        capture(0, 41);
        check("a5_start_latency", 0, cap_tx[0], 1'b0);
        for (int b = 0; b < 10; b++) check("a5_bit", 0, cap_tx[4*b+1], exp_a5[b]);
        check("a5_fd_38", 0, cap_fd[38], 1'b0);
        check("a5_fd_39", 0, cap_fd[39], 1'b1);
        check("a5_busy_after", 0, cap_busy[40], 1'b0);
        wait_idle(0);

        // back-to-back 0x81 then 0x3C
        send(0, 9'h081);
        fork
            send(0, 9'h03C);
            capture(0, 81);
        join
        check("b2b_ready_1", 0, cap_rdy[1], 1'b0);
        check("b2b_ready_39", 0, cap_rdy[39], 1'b0);
        check("b2b_ready_40", 0, cap_rdy[40], 1'b1);
        check("b2b_fd_39", 0, cap_fd[39], 1'b1);
        check("b2b_fd_40", 0, cap_fd[40], 1'b0);
        check("b2b_fd_79", 0, cap_fd[79], 1'b1);
        check("b2b_stop", 0, cap_tx[39], 1'b1);
        check("b2b_no_gap", 0, cap_tx[40], 1'b0);
        check("b2b_busy_40", 0, cap_busy[40], 1'b1);
        check("b2b_3c_bit0", 0, cap_tx[45], 1'b0);
        check("b2b_3c_bit2", 0, cap_tx[53], 1'b1);
        check("b2b_busy_after", 0, cap_busy[80], 1'b0);
        wait_idle(0);

        // even and odd parity on 0xA5
        send(1, 9'h0A5);
        capture(1, 45);
        for (int b = 0; b < 11; b++) check("even_bit", 1, cap_tx[4*b+1], exp_par_e[b]);
        check("even_fd_39", 1, cap_fd[39], 1'b0);
        check("even_fd_43", 1, cap_fd[43], 1'b1);
        check("even_busy_after", 1, cap_busy[44], 1'b0);
        send(2, 9'h0A5);
        capture(2, 45);
        for (int b = 0; b < 11; b++) check("odd_bit", 2, cap_tx[4*b+1], exp_par_o[b]);
        check("odd_fd_43", 2, cap_fd[43], 1'b1);

        // 7 data bits, 2 stop bits
        send(3, 9'h055);
        capture(3, 41);
        for (int b = 0; b < 10; b++) check("d7s2_bit", 3, cap_tx[4*b+1], exp_55[b]);
        for (int k = 32; k < 40; k++) check("d7s2_stop_high", 3, cap_tx[k], 1'b1);
        check("d7s2_fd_35", 3, cap_fd[35], 1'b0);
        check("d7s2_fd_39", 3, cap_fd[39], 1'b1);
        check("d7s2_busy_after", 3, cap_busy[40], 1'b0);

        // word offered exactly in the last stop cycle with the buffer empty
        send(0, 9'h0F0);
        fork
            begin
                repeat (39) @(posedge clk);
                #1;
                send(0, 9'h00F);
            end
            capture(0, 81);
        join
        check("edge_fd_39", 0, cap_fd[39], 1'b1);
        check("edge_stop", 0, cap_tx[39], 1'b1);
        check("edge_no_gap", 0, cap_tx[40], 1'b0);
        check("edge_busy_40", 0, cap_busy[40], 1'b1);
        check("edge_0f_bit0", 0, cap_tx[45], 1'b1);
        check("edge_fd_79", 0, cap_fd[79], 1'b1);
        wait_idle(0);

        // tx_valid held high while tx_data changes every cycle
        valid[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            data[0] = 9'((i * 7 + 3) & 255);
            @(posedge clk);
            #1;
        end
        valid[0] = 1'b0;
        wait_idle(0);

        // reset in the middle of the data bits with a word buffered
        send(0, 9'h05A);
        send(0, 9'h0C3);
        repeat (12) @(posedge clk);
        #2;
        check("pre_rst_tx_low", 0, txo[0], 1'b0);
        check("pre_rst_ready", 0, ready[0], 1'b0);
        rst_n = 1'b1;
        #1;
        check("async_rst_tx_out", 0, txo[0], 1'b1);
        check("async_rst_ready", 0, ready[0], 1'b1);
        check("async_rst_busy", 0, busy[0], 1'b0);
        check("async_rst_fd", 0, fdone[0], 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(0, 9'h000);
        capture(0, 41);
        for (int k = 0; k < 36; k++) check("post_rst_low", 0, cap_tx[k], 1'b0);
        for (int k = 36; k < 40; k++) check("post_rst_stop", 0, cap_tx[k], 1'b1);
        check("post_rst_fd_39", 0, cap_fd[39], 1'b1);
        check("post_rst_busy_after", 0, cap_busy[40], 1'b0);

        for (int d = 0; d < ND; d++) wait_idle(d);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
